// File: rtl/uart_msg_pkg.sv
// Shared definitions for the 20-bit UART message protocol: {payload, tag}.
// Widths, the message layout, and the initiator state encoding.
package uart_msg_pkg;

    localparam int MSG_W = 20;
    localparam int TAG_W = 4;
    localparam int PAY_W = MSG_W - TAG_W;

    typedef struct packed {
        logic [PAY_W-1:0] payload;
        logic [TAG_W-1:0] tag;
    } msg_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        WAIT = 2'd2
    } init_state_t;

    function automatic msg_t pack_msg(input logic [PAY_W-1:0] payload,
                                      input logic [TAG_W-1:0] tag);
        msg_t m;
        m.payload = payload;
        m.tag     = tag;
        return m;
    endfunction

endpackage

// File: rtl/timeout_counter.sv
// Down-counter for the per-attempt reply budget: load to CYCLES-1, count down
// while enabled, and flag zero. It holds at zero rather than wrapping.
module timeout_counter #(
    parameter int CYCLES = 8,
    parameter int CNT_W  = $clog2(CYCLES)
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic load_i,
    input  logic enable_i,
    output logic zero_o
);

    logic [CNT_W-1:0] count_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else if (load_i) begin
            count_q <= CNT_W'(CYCLES - 1);
        end else if (enable_i && (count_q != '0)) begin
            count_q <= count_q - CNT_W'(1);
        end
    end

    assign zero_o = (count_q == '0);

endmodule

// File: rtl/uart_request_initiator.sv
// Host-side initiator: sends one tagged request, waits for the reply with the
// same tag, resends on timeout, and reports the payload or an error.
// Client handshake: a request transfers on a cycle with req_valid && req_ready;
// the client must hold req_valid/req_payload until then. Responses are a
// one-cycle rsp_valid strobe with no back-pressure.
module uart_request_initiator
    import uart_msg_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 50_000_000,
    parameter int MAX_RETRIES    = 3
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              req_valid,
    input  logic [PAY_W-1:0]  req_payload,
    output logic              req_ready,
    input  logic              tx_ready,
    output logic              tx_isNew,
    output logic [MSG_W-1:0]  tx_message,
    input  logic              rx_isNew,
    input  logic [MSG_W-1:0]  rx_message,
    output logic              rsp_valid,
    output logic [PAY_W-1:0]  rsp_payload,
    output logic              rsp_error,
    output init_state_t       dbg_state
);

    localparam int RETRY_W = (MAX_RETRIES < 1) ? 1 : $clog2(MAX_RETRIES + 1);

    init_state_t        state_q;
    logic [TAG_W-1:0]   tag_q;
    logic [TAG_W-1:0]   tag_d;
    logic [RETRY_W-1:0] retries_q;
    msg_t               msg_q;
    logic               tx_isNew_q;
    logic               rsp_valid_q;
    logic [PAY_W-1:0]   rsp_payload_q;
    logic               rsp_error_q;

    msg_t rx_msg;
    logic tag_match;
    logic timer_load;
    logic timer_en;
    logic timer_zero;

    assign tag_d      = tag_q + TAG_W'(1);
    assign rx_msg     = rx_message;
    assign tag_match  = rx_isNew && (rx_msg.tag == tag_q);
    assign timer_load = (state_q == SEND) && tx_ready;
    assign timer_en   = (state_q == WAIT);

    timeout_counter #(
        .CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk_i    (clock),
        .rst_ni   (reset_n),
        .load_i   (timer_load),
        .enable_i (timer_en),
        .zero_o   (timer_zero)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            tag_q         <= '0;
            retries_q     <= '0;
            msg_q         <= '0;
            tx_isNew_q    <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_payload_q <= '0;
            rsp_error_q   <= 1'b0;
        end else begin
            tx_isNew_q  <= 1'b0;
            rsp_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        tag_q     <= tag_d;
                        msg_q     <= pack_msg(req_payload, tag_d);
                        retries_q <= '0;
                        state_q   <= SEND;
                    end
                end
                SEND: begin
                    if (tx_ready) begin
                        tx_isNew_q <= 1'b1;
                        state_q    <= WAIT;
                    end
                end
                WAIT: begin
                    // A matching reply on the last budget cycle still counts as success.
                    if (tag_match) begin
                        rsp_payload_q <= rx_msg.payload;
                        rsp_error_q   <= 1'b0;
                        rsp_valid_q   <= 1'b1;
                        state_q       <= IDLE;
                    end else if (timer_zero) begin
                        if (retries_q < RETRY_W'(MAX_RETRIES)) begin
                            retries_q <= retries_q + RETRY_W'(1);
                            state_q   <= SEND;
                        end else begin
                            rsp_payload_q <= '0;
                            rsp_error_q   <= 1'b1;
                            rsp_valid_q   <= 1'b1;
                            state_q       <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_ready   = (state_q == IDLE);
    assign tx_isNew    = tx_isNew_q;
    assign tx_message  = msg_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_payload = rsp_payload_q;
    assign rsp_error   = rsp_error_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_uart_request_initiator.sv
// Directed bench for uart_request_initiator with a short 8-cycle reply budget.
module tb_uart_request_initiator;
    import uart_msg_pkg::*;

    logic              clock = 1'b0;
    logic              reset_n;
    logic              req_valid;
    logic [PAY_W-1:0]  req_payload;
    logic              req_ready;
    logic              tx_ready;
    logic              tx_isNew;
    logic [MSG_W-1:0]  tx_message;
    logic              rx_isNew;
    logic [MSG_W-1:0]  rx_message;
    logic              rsp_valid;
    logic [PAY_W-1:0]  rsp_payload;
    logic              rsp_error;
    init_state_t       dbg_state;

    int n_checks = 0;
    int n_fail   = 0;

    uart_request_initiator #(
        .TIMEOUT_CYCLES (8),
        .MAX_RETRIES    (3)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .req_valid   (req_valid),
        .req_payload (req_payload),
        .req_ready   (req_ready),
        .tx_ready    (tx_ready),
        .tx_isNew    (tx_isNew),
        .tx_message  (tx_message),
        .rx_isNew    (rx_isNew),
        .rx_message  (rx_message),
        .rsp_valid   (rsp_valid),
        .rsp_payload (rsp_payload),
        .rsp_error   (rsp_error),
        .dbg_state   (dbg_state)
    );

    // clock / reset
    always #5 clock = ~clock;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Inputs change and outputs are sampled at the falling edge.
    task automatic step();
        @(negedge clock);
    endtask

    task automatic do_reset();
        reset_n   = 1'b0;
        req_valid = 1'b0;
        rx_isNew  = 1'b0;
        step();
        reset_n = 1'b1;
        step();
    endtask

    task automatic issue_request(input logic [PAY_W-1:0] p, output int lat);
        req_valid   = 1'b1;
        req_payload = p;
        lat = -1;
        for (int i = 1; i <= 30; i++) begin
            step();
            req_valid = 1'b0;
            if (tx_isNew) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic reply(input logic [MSG_W-1:0] m);
        rx_message = m;
        rx_isNew   = 1'b1;
        step();
        rx_isNew = 1'b0;
    endtask

    task automatic wait_pulse(input int max, output int n, output logic saw_tx, output logic saw_rsp);
        n = -1;
        saw_tx = 1'b0;
        saw_rsp = 1'b0;
        for (int i = 1; i <= max; i++) begin
            step();
            if (tx_isNew || rsp_valid) begin
                n = i;
                saw_tx = tx_isNew;
                saw_rsp = rsp_valid;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset_n     = 1'b0;
        req_valid   = 1'b0;
        req_payload = '0;
        tx_ready    = 1'b0;
        rx_isNew    = 1'b0;
        rx_message  = '0;
        step();
        step();
        n_checks++;
        if ({tx_isNew, tx_message, rsp_valid, rsp_payload, rsp_error, req_ready} !== {1'b0, 20'h0, 1'b0, 16'h0, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL reset_outputs: got isNew=%b msg=%h vld=%b pay=%h err=%b rdy=%b expected 0 00000 0 0000 0 1",
                     tx_isNew, tx_message, rsp_valid, rsp_payload, rsp_error, req_ready);
        end
        n_checks++;
        if (dbg_state !== IDLE) begin
            n_fail++;
            $display("FAIL reset_state: got %0d expected %0d", dbg_state, IDLE);
        end
        reset_n = 1'b1;
        step();
    endtask

    task automatic test_basic();
        int lat;
        tx_ready = 1'b1;
        issue_request(16'hABCD, lat);
        n_checks++;
        if (lat != 2) begin
            n_fail++;
            $display("FAIL basic_latency: got %0d expected 2", lat);
        end
        n_checks++;
        if (tx_message !== 20'hABCD1) begin
            n_fail++;
            $display("FAIL basic_tx_message: got %h expected abcd1", tx_message);
        end
        step();
        n_checks++;
        if (tx_isNew !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_strobe_width: got %b expected 0", tx_isNew);
        end
        reply(20'h12341);
        n_checks++;
        if ({rsp_valid, rsp_payload, rsp_error, req_ready} !== {1'b1, 16'h1234, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL basic_response: got vld=%b pay=%h err=%b rdy=%b expected 1 1234 0 1",
                     rsp_valid, rsp_payload, rsp_error, req_ready);
        end
        step();
        n_checks++;
        if ({rsp_valid, rsp_payload} !== {1'b0, 16'h1234}) begin
            n_fail++;
            $display("FAIL basic_response_after: got vld=%b pay=%h expected 0 1234", rsp_valid, rsp_payload);
        end
    endtask

    task automatic test_stale_tag();
        int lat;
        do_reset();
        tx_ready = 1'b1;
        issue_request(16'h5555, lat);
        n_checks++;
        if ({lat == 2, tx_message} !== {1'b1, 20'h55551}) begin
            n_fail++;
            $display("FAIL stale_request: got lat=%0d msg=%h expected lat=2 msg=55551", lat, tx_message);
        end
        step();
        reply(20'hBEEF0);
        n_checks++;
        if ({rsp_valid, dbg_state} !== {1'b0, WAIT}) begin
            n_fail++;
            $display("FAIL stale_ignored: got vld=%b state=%0d expected 0 %0d", rsp_valid, dbg_state, WAIT);
        end
        reply(20'hCAFE1);
        n_checks++;
        if ({rsp_valid, rsp_payload, rsp_error} !== {1'b1, 16'hCAFE, 1'b0}) begin
            n_fail++;
            $display("FAIL stale_then_match: got vld=%b pay=%h err=%b expected 1 cafe 0", rsp_valid, rsp_payload, rsp_error);
        end
        step();
    endtask

    task automatic test_timeout();
        int lat;
        int n;
        logic saw_tx;
        logic saw_rsp;
        tx_ready = 1'b1;
        issue_request(16'h0F0F, lat);
        n_checks++;
        if ({lat == 2, tx_message} !== {1'b1, 20'h0F0F2}) begin
            n_fail++;
            $display("FAIL timeout_first_send: got lat=%0d msg=%h expected lat=2 msg=0f0f2", lat, tx_message);
        end
        for (int k = 1; k <= 3; k++) begin
            wait_pulse(20, n, saw_tx, saw_rsp);
            n_checks++;
            if ({n == 9, saw_tx, saw_rsp, tx_message} !== {1'b1, 1'b1, 1'b0, 20'h0F0F2}) begin
                n_fail++;
                $display("FAIL timeout_resend_%0d: got gap=%0d tx=%b rsp=%b msg=%h expected gap=9 tx=1 rsp=0 msg=0f0f2",
                         k, n, saw_tx, saw_rsp, tx_message);
            end
        end
        wait_pulse(20, n, saw_tx, saw_rsp);
        n_checks++;
        if ({n == 8, saw_tx, saw_rsp, rsp_error, rsp_payload} !== {1'b1, 1'b0, 1'b1, 1'b1, 16'h0}) begin
            n_fail++;
            $display("FAIL timeout_error: got gap=%0d tx=%b rsp=%b err=%b pay=%h expected gap=8 tx=0 rsp=1 err=1 pay=0000",
                     n, saw_tx, saw_rsp, rsp_error, rsp_payload);
        end
        step();
        n_checks++;
        if ({rsp_valid, rsp_error, req_ready} !== {1'b0, 1'b1, 1'b1}) begin
            n_fail++;
            $display("FAIL timeout_after: got vld=%b err=%b rdy=%b expected 0 1 1", rsp_valid, rsp_error, req_ready);
        end
    endtask

    task automatic test_tx_stall();
        int stray;
        tx_ready    = 1'b0;
        req_valid   = 1'b1;
        req_payload = 16'h4444;
        step();
        req_payload = 16'h9999;
        stray = 0;
        for (int i = 0; i < 5; i++) begin
            if (tx_isNew || req_ready || dbg_state != SEND) stray++;
            step();
        end
        n_checks++;
        if (stray != 0) begin
            n_fail++;
            $display("FAIL stall_hold: got %0d bad cycles expected 0", stray);
        end
        req_valid = 1'b0;
        tx_ready  = 1'b1;
        step();
        n_checks++;
        if ({tx_isNew, tx_message} !== {1'b1, 20'h44443}) begin
            n_fail++;
            $display("FAIL stall_release: got isNew=%b msg=%h expected 1 44443", tx_isNew, tx_message);
        end
        stray = 0;
        for (int i = 0; i < 7; i++) begin
            step();
            if (tx_isNew || rsp_valid) stray++;
        end
        reply(20'h77773);
        n_checks++;
        if ({stray, rsp_valid, rsp_payload, rsp_error} !== {32'd0, 1'b1, 16'h7777, 1'b0}) begin
            n_fail++;
            $display("FAIL stall_full_budget: got stray=%0d vld=%b pay=%h err=%b expected 0 1 7777 0",
                     stray, rsp_valid, rsp_payload, rsp_error);
        end
        step();
    endtask

    task automatic test_tag_wrap();
        int lat;
        int stray;
        logic [PAY_W-1:0] p;
        logic [TAG_W-1:0] exp_tag;
        do_reset();
        tx_ready = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            p = 16'hA000 + 16'(i);
            exp_tag = 4'(i);
            issue_request(p, lat);
            n_checks++;
            if ({lat == 2, tx_message} !== {1'b1, p, exp_tag}) begin
                n_fail++;
                $display("FAIL wrap_send_%0d: got lat=%0d msg=%h expected lat=2 msg=%h", i, lat, tx_message, {p, exp_tag});
            end
            stray = 0;
            if (i < 16) begin
                step();
            end else begin
                for (int k = 0; k < 7; k++) begin
                    step();
                    if (tx_isNew || rsp_valid) stray++;
                end
            end
            reply({~p, exp_tag});
            n_checks++;
            if ({stray, rsp_valid, rsp_payload, rsp_error} !== {32'd0, 1'b1, ~p, 1'b0}) begin
                n_fail++;
                $display("FAIL wrap_reply_%0d: got stray=%0d vld=%b pay=%h err=%b expected 0 1 %h 0",
                         i, stray, rsp_valid, rsp_payload, rsp_error, ~p);
            end
        end
        stray = 0;
        for (int k = 0; k < 12; k++) begin
            step();
            if (tx_isNew || rsp_valid || !req_ready) stray++;
        end
        n_checks++;
        if (stray != 0) begin
            n_fail++;
            $display("FAIL wrap_no_resend: got %0d bad cycles expected 0", stray);
        end
    endtask

    task automatic test_reset_abort();
        int lat;
        tx_ready = 1'b1;
        issue_request(16'h3333, lat);
        n_checks++;
        if (tx_message !== 20'h33331) begin
            n_fail++;
            $display("FAIL abort_first_tag: got %h expected 33331", tx_message);
        end
        step();
        step();
        reset_n = 1'b0;
        #1;
        n_checks++;
        if ({tx_isNew, tx_message, rsp_valid, rsp_payload, rsp_error, req_ready, dbg_state} !==
            {1'b0, 20'h0, 1'b0, 16'h0, 1'b0, 1'b1, IDLE}) begin
            n_fail++;
            $display("FAIL abort_outputs: got isNew=%b msg=%h vld=%b pay=%h err=%b rdy=%b st=%0d expected 0 00000 0 0000 0 1 0",
                     tx_isNew, tx_message, rsp_valid, rsp_payload, rsp_error, req_ready, dbg_state);
        end
        step();
        reset_n = 1'b1;
        step();
        reply(20'hDEAD1);
        n_checks++;
        if ({rsp_valid, dbg_state} !== {1'b0, IDLE}) begin
            n_fail++;
            $display("FAIL abort_idle_rx_ignored: got vld=%b st=%0d expected 0 0", rsp_valid, dbg_state);
        end
        issue_request(16'h6666, lat);
        n_checks++;
        if ({lat == 2, tx_message} !== {1'b1, 20'h66661}) begin
            n_fail++;
            $display("FAIL abort_next_tag: got lat=%0d msg=%h expected lat=2 msg=66661", lat, tx_message);
        end
        step();
        reply(20'h88881);
        n_checks++;
        if ({rsp_valid, rsp_payload, rsp_error} !== {1'b1, 16'h8888, 1'b0}) begin
            n_fail++;
            $display("FAIL abort_next_reply: got vld=%b pay=%h err=%b expected 1 8888 0", rsp_valid, rsp_payload, rsp_error);
        end
        step();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stale_tag();
        test_timeout();
        test_tx_stall();
        test_tag_wrap();
        test_reset_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
